// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the code lock sequencer: state encoding,
// digit markers and the entry-validity check.
package code_lock_pkg;

  localparam int CODE_W = 16;
  localparam logic [3:0] DIGIT_BLANK = 4'ha;
  localparam logic [3:0] DIGIT_ERR   = 4'hb;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    CHECK        = 3'd1,
    OPEN         = 3'd2,
    PROG_NEW     = 3'd3,
    PROG_CONFIRM = 3'd4,
    LOCKOUT      = 3'd5
  } state_t;

  // An entry is usable only if every digit is a decimal key.
  function automatic logic digits_valid(input logic [CODE_W-1:0] c);
    logic ok;
    logic [3:0] d;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = c[i*4 +: 4];
      if (d > 4'd9 || d == DIGIT_BLANK || d == DIGIT_ERR) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Loadable down-counter shared by the unlock, programming-window and
// lockout intervals. Decrement stops at zero.
module lock_timer #(
  parameter int TIMER_W = 27
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               is_zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock sequencer: checks completed keypad entries, drives unlock/alarm,
// counts failures and handles code reprogramming. Optional master code
// under CODE_LOCK_MASTER_CODE_EN.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int          TIMER_W        = 27,
  parameter int          UNLOCK_CYCLES  = 100000000,
  parameter int          LOCKOUT_CYCLES = 100000000,
  parameter int          MAX_FAILS      = 3,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234
`ifdef CODE_LOCK_MASTER_CODE_EN
  ,
  parameter logic [15:0] MASTER_CODE    = 16'h9999
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        code_valid,
  input  logic [15:0] code,
  input  logic        prog_req,
  input  logic        lock_req,
  output logic        unlock,
  output logic        alarm,
  output logic        prog_mode,
  output logic        err,
  output logic        prog_ok,
  output logic [2:0]  fail_cnt,
  output logic [2:0]  state_dbg
);

  localparam logic [TIMER_W-1:0] UNLOCK_LD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]         MAX_F      = 3'(MAX_FAILS);

  state_t             state, state_n;
  logic [15:0]        entry_reg, entry_n;
  logic [15:0]        pending_reg, pending_n;
  logic [15:0]        stored_code, stored_n;
  logic [2:0]         fail_n;
  logic               err_n, prog_ok_n;
  logic               timer_load, timer_dec, timer_zero;
  logic [TIMER_W-1:0] timer_val;
  logic               entry_match;

`ifdef CODE_LOCK_MASTER_CODE_EN
  logic master_hit;
  assign entry_match = digits_valid(entry_reg) &&
                       (entry_reg == stored_code || entry_reg == MASTER_CODE);
  assign master_hit  = code_valid && digits_valid(code) && (code == MASTER_CODE);
`else
  assign entry_match = digits_valid(entry_reg) && (entry_reg == stored_code);
`endif

  lock_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .is_zero  (timer_zero)
  );

  always_comb begin
    state_n    = state;
    entry_n    = entry_reg;
    pending_n  = pending_reg;
    stored_n   = stored_code;
    fail_n     = fail_cnt;
    err_n      = 1'b0;
    prog_ok_n  = 1'b0;
    timer_load = 1'b0;
    timer_val  = UNLOCK_LD;
    timer_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (code_valid) begin
          entry_n = code;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (entry_match) begin
          state_n    = OPEN;
          fail_n     = '0;
          timer_load = 1'b1;
        end else begin
          err_n = 1'b1;
          if (fail_cnt + 3'd1 == MAX_F) begin
            state_n    = LOCKOUT;
            fail_n     = MAX_F;
            timer_load = 1'b1;
            timer_val  = LOCKOUT_LD;
          end else begin
            fail_n  = fail_cnt + 3'd1;
            state_n = IDLE;
          end
        end
      end
      // Relock wins over reprogramming, which wins over expiry.
      OPEN: begin
        if (lock_req) begin
          state_n = IDLE;
        end else if (prog_req) begin
          state_n    = PROG_NEW;
          timer_load = 1'b1;
        end else if (timer_zero) begin
          state_n = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      PROG_NEW: begin
        if (code_valid) begin
          if (digits_valid(code)) begin
            pending_n  = code;
            timer_load = 1'b1;
            state_n    = PROG_CONFIRM;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (timer_zero) begin
          state_n = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      PROG_CONFIRM: begin
        if (code_valid) begin
          if (code == pending_reg) begin
            stored_n  = code;
            prog_ok_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end else if (timer_zero) begin
          state_n = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      LOCKOUT: begin
`ifdef CODE_LOCK_MASTER_CODE_EN
        if (master_hit) begin
          state_n    = OPEN;
          fail_n     = '0;
          timer_load = 1'b1;
        end else
`endif
        if (timer_zero) begin
          state_n = IDLE;
          fail_n  = '0;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      entry_reg   <= '0;
      pending_reg <= '0;
      stored_code <= DEFAULT_CODE;
      fail_cnt    <= '0;
      unlock      <= 1'b0;
      alarm       <= 1'b0;
      prog_mode   <= 1'b0;
      err         <= 1'b0;
      prog_ok     <= 1'b0;
    end else begin
      state       <= state_n;
      entry_reg   <= entry_n;
      pending_reg <= pending_n;
      stored_code <= stored_n;
      fail_cnt    <= fail_n;
      unlock      <= (state_n == OPEN);
      alarm       <= (state_n == LOCKOUT);
      prog_mode   <= (state_n == PROG_NEW) || (state_n == PROG_CONFIRM);
      err         <= err_n;
      prog_ok     <= prog_ok_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed-sequence bench for code_lock_ctrl with randomized codes checked
// against an entry-level model of the lock (stored code, failure count).
module tb_code_lock_ctrl;

  localparam int          UNLOCK_CYCLES  = 8;
  localparam int          LOCKOUT_CYCLES = 16;
  localparam int          MAX_FAILS      = 3;
  localparam logic [15:0] DEFAULT_CODE   = 16'h1234;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        code_valid = 1'b0;
  logic [15:0] code = '0;
  logic        prog_req = 1'b0;
  logic        lock_req = 1'b0;
  logic        unlock, alarm, prog_mode, err, prog_ok;
  logic [2:0]  fail_cnt, state_dbg;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_code;
  int          m_fails;
  logic [2:0]  exp_q[$];

  always #5 clk = ~clk;

  code_lock_ctrl #(
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .MAX_FAILS      (MAX_FAILS),
    .DEFAULT_CODE   (DEFAULT_CODE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .code       (code),
    .prog_req   (prog_req),
    .lock_req   (lock_req),
    .unlock     (unlock),
    .alarm      (alarm),
    .prog_mode  (prog_mode),
    .err        (err),
    .prog_ok    (prog_ok),
    .fail_cnt   (fail_cnt),
    .state_dbg  (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid(input logic [15:0] c);
    for (int i = 0; i < 4; i++) if (c[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    for (int i = 0; i < 4; i++) c[i*4 +: 4] = 4'($urandom_range(0, 9));
    return c;
  endfunction

  function automatic logic [15:0] rand_other(input logic [15:0] avoid);
    logic [15:0] c;
    c = rand_code();
    while (c == avoid) c = rand_code();
    return c;
  endfunction

  task automatic enter(input logic [15:0] c);
    code       = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  // Entry from the idle prompt; outcome predicted from the stored code and failure count.
  task automatic try_code(input string tag, input logic [15:0] c);
    bit hit;
    hit = is_valid(c) && (c == m_code);
    if (hit) m_fails = 0;
    else m_fails = m_fails + 1;
    exp_q.push_back(3'(m_fails));
    enter(c);
    tick();
    chk({tag, "_unlock"}, 16'(unlock), 16'(hit));
    chk({tag, "_err"}, 16'(err), 16'(!hit));
    chk({tag, "_alarm"}, 16'(alarm), 16'(m_fails == MAX_FAILS));
    chk({tag, "_fail_cnt"}, 16'(fail_cnt), 16'(exp_q.pop_front()));
  endtask

  initial begin
    int          cnt;
    bit          stray;
    logic [15:0] c, c2, c3, old_code;
    int          pos;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_unlock", 16'(unlock), 16'd0);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_prog_mode", 16'(prog_mode), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_prog_ok", 16'(prog_ok), 16'd0);
    chk("rst_fail_cnt", 16'(fail_cnt), 16'd0);
    #4 reset_n = 1'b1;
    m_code  = DEFAULT_CODE;
    m_fails = 0;

    // Correct code: unlock held for the unlock interval
    try_code("open1", DEFAULT_CODE);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (unlock) cnt++;
      tick();
    end
    chk("open1_len", 16'(cnt), 16'(UNLOCK_CYCLES));
    chk("open1_after", 16'(unlock), 16'd0);

    // Three wrong codes lead to lockout; an entry during lockout is ignored
    for (int k = 0; k < MAX_FAILS; k++) begin
      try_code("wrong", rand_other(m_code));
      if (k < MAX_FAILS - 1) begin
        tick();
        chk("wrong_err_pulse", 16'(err), 16'd0);
      end
    end
    cnt   = 0;
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      code_valid = (i == 2);
      code       = DEFAULT_CODE;
      if (alarm) cnt++;
      if ((err && i > 0) || unlock) stray = 1'b1;
      tick();
    end
    code_valid = 1'b0;
    m_fails    = 0;
    chk("lock_len", 16'(cnt), 16'(LOCKOUT_CYCLES));
    chk("lock_ignored", 16'(stray), 16'd0);
    chk("lock_fail_clr", 16'(fail_cnt), 16'd0);
    chk("lock_alarm_off", 16'(alarm), 16'd0);

    // Invalid digits count as mismatches
    try_code("inv_fixed", 16'h12b4);
    c   = rand_code();
    pos = $urandom_range(0, 3);
    c[pos*4 +: 4] = 4'($urandom_range(10, 11));
    try_code("inv_rand", c);
    try_code("open2", m_code);

    // Reprogram to a new random code
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    chk("prog_enter_mode", 16'(prog_mode), 16'd1);
    chk("prog_enter_unlock", 16'(unlock), 16'd0);
    c2 = rand_other(DEFAULT_CODE);
    enter(c2);
    chk("prog_new_mode", 16'(prog_mode), 16'd1);
    chk("prog_new_err", 16'(err), 16'd0);
    enter(c2);
    chk("prog_ok_pulse", 16'(prog_ok), 16'd1);
    chk("prog_done_mode", 16'(prog_mode), 16'd0);
    tick();
    chk("prog_ok_clr", 16'(prog_ok), 16'd0);
    m_code = c2;
    try_code("old_code", DEFAULT_CODE);
    try_code("new_code", m_code);

    // Confirm mismatch keeps the stored code
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    c2 = rand_code();
    c3 = c2;
    c3[3:0] = 4'((c2[3:0] + 4'd1) % 4'd10);
    enter(c2);
    enter(c3);
    chk("conf_err", 16'(err), 16'd1);
    chk("conf_prog_ok", 16'(prog_ok), 16'd0);
    chk("conf_mode", 16'(prog_mode), 16'd0);
    try_code("conf_kept", m_code);

    // Programming window expires silently
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    cnt   = 0;
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (prog_mode) cnt++;
      if (err || prog_ok || unlock) stray = 1'b1;
      tick();
    end
    chk("prog_to_len", 16'(cnt), 16'(UNLOCK_CYCLES));
    chk("prog_to_quiet", 16'(stray), 16'd0);

    // Reset mid-open drops unlock at once and restores the default code
    try_code("open3", m_code);
    old_code = m_code;
    reset_n  = 1'b0;
    #1;
    chk("arst_unlock", 16'(unlock), 16'd0);
    #3 reset_n = 1'b1;
    m_code  = DEFAULT_CODE;
    m_fails = 0;
    try_code("post_rst_old", old_code);
    try_code("post_rst_dflt", DEFAULT_CODE);

    // Relock request
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    chk("relock_unlock", 16'(unlock), 16'd0);
    try_code("relock_reopen", DEFAULT_CODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
